data_stack: RTL and testbench

- Operand stack engine that sits directly upstream of the processor's top-of-stack output.
- Executes one stack command per clock from the decode/execute stage.
- Exposes registered top and next-on-stack (NOS) values to the ALU.
- Reports depth and full/empty status, plus overflow/underflow errors.

---
 rtl/data_stack.sv | 138 +++++++++++++
 tb/tb_data_stack.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/data_stack.sv
// Operand stack with registered top/nos and array storage below nos.
// DATA_STACK_ERR_STICKY_EN: err holds until reset or CLEAR instead of pulsing.
module data_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2:0]               cmd,
  input  logic signed [WIDTH-1:0]  din,
  output logic signed [WIDTH-1:0]  top,
  output logic signed [WIDTH-1:0]  nos,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     empty,
  output logic                     full,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;
  localparam logic [DW-1:0] DMAX = DW'(DEPTH);

  typedef enum logic [2:0] {
    C_NOP   = 3'b000,
    C_PUSH  = 3'b001,
    C_POP   = 3'b010,
    C_DUP   = 3'b011,
    C_SWAP  = 3'b100,
    C_REPL2 = 3'b101,
    C_OVER  = 3'b110,
    C_CLEAR = 3'b111
  } cmd_e;

  logic signed [WIDTH-1:0] mem [DEPTH];
  logic signed [WIDTH-1:0] top_q, nos_q, top_n, nos_n;
  logic signed [WIDTH-1:0] below;
  logic [DW-1:0]           depth_q, depth_n;
  logic                    err_q, err_n;
  logic                    has1, has2, has3, room;
  logic                    bad, wr_en;
  logic [AW-1:0]           widx, ridx;

  assign has1 = depth_q != '0;
  assign has2 = depth_q >= DW'(2);
  assign has3 = depth_q >= DW'(3);
  assign room = depth_q != DMAX;
  assign widx = AW'(depth_q - DW'(2));
  assign ridx = AW'(depth_q - DW'(3));
  // entry that surfaces into nos when the stack shrinks by one
  assign below = has3 ? mem[ridx] : '0;

  always_comb begin
    top_n   = top_q;
    nos_n   = nos_q;
    depth_n = depth_q;
    wr_en   = 1'b0;
    bad     = 1'b0;
    unique case (cmd_e'(cmd))
      C_NOP: ;
      C_PUSH, C_DUP, C_OVER: begin
        if (!room || (cmd_e'(cmd) == C_DUP && !has1)
            || (cmd_e'(cmd) == C_OVER && !has2)) begin
          bad = 1'b1;
        end else begin
          wr_en   = has2;
          nos_n   = top_q;
          depth_n = depth_q + DW'(1);
          if (cmd_e'(cmd) == C_PUSH)     top_n = din;
          else if (cmd_e'(cmd) == C_DUP) top_n = top_q;
          else                           top_n = nos_q;
        end
      end
      C_POP: begin
        if (!has1) begin
          bad = 1'b1;
        end else begin
          top_n   = nos_q;
          nos_n   = below;
          depth_n = depth_q - DW'(1);
        end
      end
      C_SWAP: begin
        if (!has2) begin
          bad = 1'b1;
        end else begin
          top_n = nos_q;
          nos_n = top_q;
        end
      end
      C_REPL2: begin
        if (!has2) begin
          bad = 1'b1;
        end else begin
          top_n   = din;
          nos_n   = below;
          depth_n = depth_q - DW'(1);
        end
      end
      C_CLEAR: begin
        top_n   = '0;
        nos_n   = '0;
        depth_n = '0;
      end
    endcase
  end

`ifdef DATA_STACK_ERR_STICKY_EN
  assign err_n = (cmd_e'(cmd) == C_CLEAR) ? 1'b0 : (err_q | bad);
`else
  assign err_n = bad;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      top_q   <= '0;
      nos_q   <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      top_q   <= top_n;
      nos_q   <= nos_n;
      depth_q <= depth_n;
      err_q   <= err_n;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[widx] <= nos_q;
  end

  assign top   = top_q;
  assign nos   = nos_q;
  assign depth = depth_q;
  assign empty = depth_q == '0;
  assign full  = depth_q == DMAX;
  assign err   = err_q;

endmodule

// File: tb/tb_data_stack.sv
// Bench for data_stack: queue reference model compared every cycle,
// plus directed literal checks.
module tb_data_stack;

  localparam int W = 32;
  localparam int D = 16;
`ifdef DATA_STACK_ERR_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [2:0]           cmd = 3'd0;
  logic signed [W-1:0]  din = '0;
  logic signed [W-1:0]  top, nos;
  logic [$clog2(D):0]   depth;
  logic                 empty, full, err;

  data_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .cmd(cmd), .din(din),
    .top(top), .nos(nos), .depth(depth),
    .empty(empty), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit en = 1'b0;

  logic signed [W-1:0] q[$];
  bit m_err = 1'b0;

  task automatic model_step(input logic [2:0] c, input logic signed [W-1:0] d);
    int n;
    bit ok;
    logic signed [W-1:0] t;
    n = q.size();
    ok = 1'b1;
    case (c)
      3'd1: if (n < D) q.push_back(d); else ok = 1'b0;
      3'd2: if (n >= 1) t = q.pop_back(); else ok = 1'b0;
      3'd3: if (n >= 1 && n < D) q.push_back(q[n-1]); else ok = 1'b0;
      3'd4: if (n >= 2) begin
              t = q[n-1]; q[n-1] = q[n-2]; q[n-2] = t;
            end else ok = 1'b0;
      3'd5: if (n >= 2) begin
              t = q.pop_back(); t = q.pop_back(); q.push_back(d);
            end else ok = 1'b0;
      3'd6: if (n >= 2 && n < D) q.push_back(q[n-2]); else ok = 1'b0;
      3'd7: q.delete();
      default: ;
    endcase
    if (STICKY) m_err = (c == 3'd7) ? 1'b0 : (m_err | !ok);
    else        m_err = !ok;
  endtask

  function automatic int m_top();
    return (q.size() > 0) ? int'(q[q.size()-1]) : 0;
  endfunction

  function automatic int m_nos();
    return (q.size() > 1) ? int'(q[q.size()-2]) : 0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_err = 1'b0;
    end else begin
      model_step(cmd, din);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (en) begin
      chk("m.top", int'(top), m_top());
      chk("m.nos", int'(nos), m_nos());
      chk("m.depth", int'(depth), q.size());
      chk("m.empty", int'(empty), int'(q.size() == 0));
      chk("m.full", int'(full), int'(q.size() == D));
      chk("m.err", int'(err), int'(m_err));
    end
  end

  task automatic op(input logic [2:0] c, input int d);
    cmd = c;
    din = d;
    @(posedge clk);
    #1;
    cmd = 3'd0;
    din = '0;
  endtask

  typedef struct { logic [2:0] c; int d; } vec_t;
  vec_t mix[] = '{
    '{3'd1, -100}, '{3'd1, 200}, '{3'd1, -300}, '{3'd6, 0},
    '{3'd4, 0}, '{3'd5, 42}, '{3'd3, 0}, '{3'd5, -1},
    '{3'd2, 0}, '{3'd2, 0}, '{3'd2, 0}, '{3'd5, 5},
    '{3'd1, 32'h8000_0000}, '{3'd6, 0}, '{3'd7, 0}, '{3'd7, 0}
  };

  initial begin
    #2 reset = 1'b0;
    #1 en = 1'b1;
    #19 reset = 1'b1;
    @(posedge clk); #1;
    chk("rst.depth", int'(depth), 0);
    chk("rst.top", int'(top), 0);
    chk("rst.empty", int'(empty), 1);

    op(3'd1, 5); op(3'd1, -3);
    chk("t1.top", int'(top), -3);
    chk("t1.nos", int'(nos), 5);
    chk("t1.depth", int'(depth), 2);
    op(3'd5, 2);
    chk("t1r.top", int'(top), 2);
    chk("t1r.nos", int'(nos), 0);
    chk("t1r.depth", int'(depth), 1);
    op(3'd7, 0);

    op(3'd1, 7); op(3'd1, 9); op(3'd4, 0); op(3'd6, 0);
    chk("t2.top", int'(top), 9);
    chk("t2.nos", int'(nos), 7);
    chk("t2.depth", int'(depth), 3);
    op(3'd2, 0); op(3'd2, 0);
    chk("t2p.top", int'(top), 9);
    chk("t2p.nos", int'(nos), 0);
    chk("t2p.depth", int'(depth), 1);
    op(3'd7, 0);

    op(3'd2, 0);
    chk("t3.depth", int'(depth), 0);
    chk("t3.top", int'(top), 0);
    chk("t3.err", int'(err), 1);
    op(3'd0, 0);
    chk("t3.nop.err", int'(err), STICKY ? 1 : 0);
    op(3'd0, 0);
    op(3'd7, 0);
    chk("t3.clr.err", int'(err), 0);

    for (int i = 1; i <= D; i++) op(3'd1, i);
    chk("t4.full", int'(full), 1);
    chk("t4.top", int'(top), 16);
    chk("t4.nos", int'(nos), 15);
    op(3'd1, 99);
    chk("t4o.err", int'(err), 1);
    chk("t4o.top", int'(top), 16);
    chk("t4o.depth", int'(depth), 16);
    op(3'd3, 0); op(3'd6, 0);
    for (int i = 0; i < D; i++) op(3'd2, 0);
    chk("t4e.empty", int'(empty), 1);
    chk("t4e.top", int'(top), 0);
    chk("t4e.err", int'(err), STICKY ? 1 : 0);
    op(3'd7, 0);

    op(3'd1, 32'h7FFF_FFFF); op(3'd3, 0); op(3'd2, 0); op(3'd4, 0);
    chk("t5.top", int'(top), 32'h7FFF_FFFF);
    chk("t5.err", int'(err), 1);
    chk("t5.depth", int'(depth), 1);
    op(3'd5, 1); op(3'd6, 0);
    chk("t5b.top", int'(top), 32'h7FFF_FFFF);
    op(3'd7, 0);

    for (int i = 1; i <= 5; i++) op(3'd1, -i);
    chk("t6.depth", int'(depth), 5);
    #2 reset = 1'b0;
    #1;
    chk("t6a.depth", int'(depth), 0);
    chk("t6a.top", int'(top), 0);
    chk("t6a.nos", int'(nos), 0);
    @(negedge clk);
    #2 reset = 1'b1;
    op(3'd1, 4);
    chk("t6b.top", int'(top), 4);
    chk("t6b.depth", int'(depth), 1);

    foreach (mix[i]) op(mix[i].c, mix[i].d);
    chk("mix.depth", int'(depth), 0);

    @(negedge clk);
    #1 en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
